// File: rtl/axi_sram_resp_pkg.sv
// Shared definitions for the block-RAM burst responder.
//   BURST_BEATS : beats per line burst (one 128-bit line of 32-bit words)
//   w_state_e   : write-side FSM states
//   r_state_e   : read-side FSM states
//   BCOMP_OK    : value of bcomp reporting a successful write
package axi_sram_resp_pkg;

  localparam int unsigned BURST_BEATS = 4;

  localparam logic BCOMP_OK = 1'b1;

  typedef enum logic [1:0] {
    W_IDLE,
    W_DATA,
    W_RESP
  } w_state_e;

  typedef enum logic [1:0] {
    R_IDLE,
    R_FETCH,
    R_DATA
  } r_state_e;

endpackage

// File: rtl/axi_sram_resp_if.sv
// Channel bundle of the 32-bit burst bus.
//   aw*  : write address (valid/ready/id/addr/atop)
//   w*   : write data (valid/ready/data/strb/last)
//   b*   : write response (valid/ready/id/comp)
//   ar*  : read address (valid/ready/id/addr)
//   r*   : read data (valid/ready/id/data/last)
// master drives requests, slave (the responder) drives readies and responses.
interface axi_sram_resp_if;

  logic        awvalid;
  logic        awready;
  logic [3:0]  awid;
  logic [31:0] awaddr;
  logic [5:0]  awatop;

  logic        wvalid;
  logic        wready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast;

  logic        bvalid;
  logic        bready;
  logic [3:0]  bid;
  logic        bcomp;

  logic        arvalid;
  logic        arready;
  logic [3:0]  arid;
  logic [31:0] araddr;

  logic        rvalid;
  logic        rready;
  logic [3:0]  rid;
  logic [31:0] rdata;
  logic        rlast;

  modport master (
    output awvalid, awid, awaddr, awatop,
    output wvalid, wdata, wstrb, wlast,
    output bready,
    output arvalid, arid, araddr,
    output rready,
    input  awready, wready, bvalid, bid, bcomp,
    input  arready, rvalid, rid, rdata, rlast
  );

  modport slave (
    input  awvalid, awid, awaddr, awatop,
    input  wvalid, wdata, wstrb, wlast,
    input  bready,
    input  arvalid, arid, araddr,
    input  rready,
    output awready, wready, bvalid, bid, bcomp,
    output arready, rvalid, rid, rdata, rlast
  );

endinterface

// File: rtl/sram_be_1w1r.sv
// Simple dual-port 2^AddrWidth x 32 RAM.
//   clk_i   : clock
//   we_i    : write enable, waddr_i/wdata_i/be_i : write port with byte enables
//   raddr_i : read address, rdata_o : registered read data (one cycle latency)
// Read-first: a read and write of the same word in one cycle returns the old word.
module sram_be_1w1r #(
  parameter int unsigned AddrWidth = 14
) (
  input  logic                 clk_i,
  input  logic                 we_i,
  input  logic [AddrWidth-1:0] waddr_i,
  input  logic [31:0]          wdata_i,
  input  logic [3:0]           be_i,
  input  logic [AddrWidth-1:0] raddr_i,
  output logic [31:0]          rdata_o
);

  localparam int unsigned Depth = 2 ** AddrWidth;

  logic [31:0] mem_q [Depth];

  // No reset: contents survive rst_n and the array stays BRAM-inferable.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      for (int i = 0; i < 4; i++) begin
        if (be_i[i]) begin
          mem_q[waddr_i][8*i +: 8] <= wdata_i[8*i +: 8];
        end
      end
    end
    rdata_o <= mem_q[raddr_i];
  end

endmodule

// File: rtl/axi_sram_resp.sv
// Burst-bus responder backed by on-chip RAM. Serves 4-beat line writes and
// 4-beat line reads with independent, concurrent write and read FSMs.
//   clk   : clock
//   rst_n : asynchronous active-low reset (RAM contents are kept)
//   bus   : slave side of the aw/w/b/ar/r channel bundle
// Beat b of a burst targets word {addr[DWIDTH+1:4], b}; higher bits alias.
module axi_sram_resp
  import axi_sram_resp_pkg::*;
#(
  parameter int unsigned DWIDTH = 14
) (
  input  logic             clk,
  input  logic             rst_n,
  axi_sram_resp_if.slave   bus
);

  localparam int unsigned LineW    = DWIDTH - 2;
  localparam logic [1:0]  LastBeat = 2'(BURST_BEATS - 1);

  // Write side state
  w_state_e         w_state_q, w_state_d;
  logic [1:0]       w_beat_q, w_beat_d;
  logic [3:0]       w_id_q, w_id_d;
  logic [LineW-1:0] w_line_q, w_line_d;
  logic             w_err_q, w_err_d;
  logic             awready_q, awready_d;
  logic             wready_q, wready_d;
  logic             bvalid_q, bvalid_d;
  logic             bcomp_q, bcomp_d;

  // Read side state
  r_state_e         r_state_q, r_state_d;
  logic [1:0]       r_beat_q, r_beat_d;
  logic [3:0]       r_id_q, r_id_d;
  logic [LineW-1:0] r_line_q, r_line_d;
  logic             arready_q, arready_d;
  logic             rvalid_q, rvalid_d;
  logic             rlast_q, rlast_d;

  // RAM ports
  logic              ram_we;
  logic [DWIDTH-1:0] ram_waddr;
  logic [DWIDTH-1:0] ram_raddr;
  logic [31:0]       ram_rdata;

  logic unused_addr_bits;
  assign unused_addr_bits = ^{bus.awaddr[31:DWIDTH+2], bus.awaddr[3:0],
                              bus.araddr[31:DWIDTH+2], bus.araddr[3:0]};

  // Write FSM next state
  always_comb begin
    w_state_d = w_state_q;
    w_beat_d  = w_beat_q;
    w_id_d    = w_id_q;
    w_line_d  = w_line_q;
    w_err_d   = w_err_q;
    ram_we    = 1'b0;
    ram_waddr = {w_line_q, w_beat_q};

    unique case (w_state_q)
      W_IDLE: begin
        if (bus.awvalid && awready_q) begin
          w_id_d    = bus.awid;
          w_line_d  = bus.awaddr[DWIDTH+1:4];
          w_err_d   = (bus.awatop != 6'd0);
          w_beat_d  = 2'd0;
          w_state_d = W_DATA;
        end
      end
      W_DATA: begin
        if (bus.wvalid && wready_q) begin
          ram_we   = ~w_err_q;
          w_beat_d = w_beat_q + 2'd1;
          // wlast must mark exactly the final beat; length is fixed regardless.
          if (bus.wlast != (w_beat_q == LastBeat)) begin
            w_err_d = 1'b1;
          end
          if (w_beat_q == LastBeat) begin
            w_state_d = W_RESP;
          end
        end
      end
      W_RESP: begin
        if (bus.bready && bvalid_q) begin
          w_state_d = W_IDLE;
        end
      end
      default: w_state_d = W_IDLE;
    endcase

    awready_d = (w_state_d == W_IDLE);
    wready_d  = (w_state_d == W_DATA);
    bvalid_d  = (w_state_d == W_RESP);
    bcomp_d   = bvalid_d ? (w_err_d ? ~BCOMP_OK : BCOMP_OK) : 1'b0;
  end

  // Read FSM next state
  always_comb begin
    r_state_d = r_state_q;
    r_beat_d  = r_beat_q;
    r_id_d    = r_id_q;
    r_line_d  = r_line_q;

    unique case (r_state_q)
      R_IDLE: begin
        if (bus.arvalid && arready_q) begin
          r_id_d    = bus.arid;
          r_line_d  = bus.araddr[DWIDTH+1:4];
          r_beat_d  = 2'd0;
          r_state_d = R_FETCH;
        end
      end
      R_FETCH: begin
        r_state_d = R_DATA;
      end
      R_DATA: begin
        if (bus.rready && rvalid_q) begin
          r_beat_d = r_beat_q + 2'd1;
          if (r_beat_q == LastBeat) begin
            r_state_d = R_IDLE;
          end
        end
      end
      default: r_state_d = R_IDLE;
    endcase

    // Fetch the next beat only on a handshake; under stall the same word is
    // re-read, so the registered RAM output holds the presented beat.
    ram_raddr = {r_line_q, r_beat_d};

    arready_d = (r_state_d == R_IDLE);
    rvalid_d  = (r_state_d == R_DATA);
    rlast_d   = rvalid_d && (r_beat_d == LastBeat);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_state_q <= W_IDLE;
      w_beat_q  <= 2'd0;
      w_id_q    <= 4'd0;
      w_line_q  <= '0;
      w_err_q   <= 1'b0;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bcomp_q   <= 1'b0;
      r_state_q <= R_IDLE;
      r_beat_q  <= 2'd0;
      r_id_q    <= 4'd0;
      r_line_q  <= '0;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rlast_q   <= 1'b0;
    end else begin
      w_state_q <= w_state_d;
      w_beat_q  <= w_beat_d;
      w_id_q    <= w_id_d;
      w_line_q  <= w_line_d;
      w_err_q   <= w_err_d;
      awready_q <= awready_d;
      wready_q  <= wready_d;
      bvalid_q  <= bvalid_d;
      bcomp_q   <= bcomp_d;
      r_state_q <= r_state_d;
      r_beat_q  <= r_beat_d;
      r_id_q    <= r_id_d;
      r_line_q  <= r_line_d;
      arready_q <= arready_d;
      rvalid_q  <= rvalid_d;
      rlast_q   <= rlast_d;
    end
  end

  sram_be_1w1r #(
    .AddrWidth(DWIDTH)
  ) u_sram (
    .clk_i  (clk),
    .we_i   (ram_we),
    .waddr_i(ram_waddr),
    .wdata_i(bus.wdata),
    .be_i   (bus.wstrb),
    .raddr_i(ram_raddr),
    .rdata_o(ram_rdata)
  );

  assign bus.awready = awready_q;
  assign bus.wready  = wready_q;
  assign bus.bvalid  = bvalid_q;
  assign bus.bid     = w_id_q;
  assign bus.bcomp   = bcomp_q;
  assign bus.arready = arready_q;
  assign bus.rvalid  = rvalid_q;
  assign bus.rid     = r_id_q;
  assign bus.rlast   = rlast_q;
  // The RAM output register has no reset, so qualify it to read zero when idle.
  assign bus.rdata   = rvalid_q ? ram_rdata : 32'd0;

endmodule

// File: tb/tb_axi_sram_resp.sv
module tb_axi_sram_resp;

  localparam int unsigned DW = 14;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   n_vec = 0;
  int   n_err = 0;

  logic [31:0] mem_m [int];

  axi_sram_resp_if bus ();

  axi_sram_resp #(
    .DWIDTH(DW)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int widx(input logic [31:0] a, input int b);
    return int'(a[DW+1:4]) * 4 + b;
  endfunction

  function automatic void model_write(input logic [31:0] a, input logic [127:0] d,
                                      input logic [15:0] s);
    logic [31:0] w;
    for (int b = 0; b < 4; b++) begin
      w = mem_m.exists(widx(a, b)) ? mem_m[widx(a, b)] : 32'd0;
      for (int j = 0; j < 4; j++) if (s[4*b+j]) w[8*j +: 8] = d[32*b + 8*j +: 8];
      mem_m[widx(a, b)] = w;
    end
  endfunction

  function automatic logic [127:0] model_line(input logic [31:0] a);
    logic [127:0] l;
    for (int b = 0; b < 4; b++) l[32*b +: 32] = mem_m[widx(a, b)];
    return l;
  endfunction

  task automatic do_write(input logic [31:0] addr, input logic [3:0] id, input logic [5:0] atop,
                          input logic [127:0] data, input logic [15:0] strb,
                          input logic [3:0] lastp, input bit stall,
                          output logic bcomp_o, output logic [3:0] bid_o,
                          output int t_aw, output int t_b, output bit ok, output bit stable);
    int guard = 0;
    int b = 0;
    bit held = 0;
    logic [4:0] hv = '0;
    ok = 1; stable = 1; t_aw = -1; t_b = -1; bcomp_o = 1'bx; bid_o = 'x;
    @(negedge clk);
    bus.awvalid = 1'b1; bus.awaddr = addr; bus.awid = id; bus.awatop = atop;
    while (!bus.awready && guard < 200) begin @(negedge clk); guard++; end
    if (!bus.awready) begin ok = 0; bus.awvalid = 1'b0; return; end
    t_aw = cyc;
    @(negedge clk);
    bus.awvalid = 1'b0;
    while (b < 4 && ok) begin
      bus.wvalid = stall ? 1'($urandom_range(1)) : 1'b1;
      bus.wdata  = data[32*b +: 32];
      bus.wstrb  = strb[4*b +: 4];
      bus.wlast  = lastp[b];
      if (bus.wvalid && bus.wready) b++;
      @(negedge clk); guard++;
      if (guard > 1000) ok = 0;
    end
    bus.wvalid = 1'b0;
    while (ok) begin
      if (bus.bvalid && t_b < 0) t_b = cyc;
      if (bus.bvalid && held && {bus.bid, bus.bcomp} !== hv) stable = 0;
      bus.bready = stall ? 1'($urandom_range(1)) : 1'b1;
      if (bus.bvalid && bus.bready) begin
        bcomp_o = bus.bcomp; bid_o = bus.bid;
        @(negedge clk);
        bus.bready = 1'b0;
        break;
      end
      held = bus.bvalid;
      hv = {bus.bid, bus.bcomp};
      @(negedge clk); guard++;
      if (guard > 1000) ok = 0;
    end
    bus.bready = 1'b0;
  endtask

  task automatic do_read(input logic [31:0] addr, input logic [3:0] id, input bit stall,
                         output logic [127:0] data, output logic [3:0] lastp,
                         output logic [3:0] rid_o, output int t_ar, output int t_first,
                         output int t_last, output bit ok, output bit stable);
    int guard = 0;
    int b = 0;
    bit held = 0;
    logic [36:0] hv = '0;
    ok = 1; stable = 1; t_ar = -1; t_first = -1; t_last = -1;
    data = 'x; lastp = '0; rid_o = 'x;
    @(negedge clk);
    bus.arvalid = 1'b1; bus.araddr = addr; bus.arid = id;
    while (!bus.arready && guard < 200) begin @(negedge clk); guard++; end
    if (!bus.arready) begin ok = 0; bus.arvalid = 1'b0; return; end
    t_ar = cyc;
    @(negedge clk);
    bus.arvalid = 1'b0;
    while (b < 4 && ok) begin
      bus.rready = stall ? 1'($urandom_range(1)) : 1'b1;
      if (bus.rvalid) begin
        if (t_first < 0) t_first = cyc;
        if (held && {bus.rid, bus.rdata, bus.rlast} !== hv) stable = 0;
        if (bus.rready) begin
          data[32*b +: 32] = bus.rdata;
          lastp[b] = bus.rlast;
          rid_o = bus.rid;
          if (b == 3) t_last = cyc;
          b++;
          held = 0;
        end else begin
          held = 1;
          hv = {bus.rid, bus.rdata, bus.rlast};
        end
      end
      @(negedge clk); guard++;
      if (guard > 1000) ok = 0;
    end
    bus.rready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_vec++;
    if ({bus.awready, bus.wready, bus.bvalid, bus.bcomp, bus.arready, bus.rvalid, bus.rlast}
        !== 7'd0) begin
      n_err++;
      $display("FAIL reset_ctrl: got %b want 0000000", {bus.awready, bus.wready, bus.bvalid,
               bus.bcomp, bus.arready, bus.rvalid, bus.rlast});
    end
    n_vec++;
    if ({bus.bid, bus.rid, bus.rdata} !== 40'd0) begin
      n_err++;
      $display("FAIL reset_data: bid=%h rid=%h rdata=%h want 0", bus.bid, bus.rid, bus.rdata);
    end
    rst_n = 1'b1;
    @(negedge clk);
    n_vec++;
    if ({bus.awready, bus.arready} !== 2'b11) begin
      n_err++;
      $display("FAIL reset_ready_rise: got %b want 11", {bus.awready, bus.arready});
    end
  endtask

  task automatic test_write_read();
    logic bc; logic [3:0] bi, ri, lp; int ta, tb, tf, tl; bit ok, st;
    logic [127:0] d = {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};
    logic [127:0] rd;
    do_write(32'h100, 4'd3, 6'd0, d, 16'hFFFF, 4'b1000, 0, bc, bi, ta, tb, ok, st);
    model_write(32'h100, d, 16'hFFFF);
    n_vec++;
    if (!ok || tb - ta != 5) begin
      n_err++; $display("FAIL wr_latency: ok=%0d bvalid at T+%0d want T+5", ok, tb - ta);
    end
    n_vec++;
    if (bi !== 4'd3 || bc !== 1'b1) begin
      n_err++; $display("FAIL wr_resp: bid=%h bcomp=%b want bid=3 bcomp=1", bi, bc);
    end
    n_vec++;
    if (bus.awready !== 1'b1) begin
      n_err++; $display("FAIL awready_after_b: got %b want 1", bus.awready);
    end
    do_read(32'h100, 4'd5, 0, rd, lp, ri, ta, tf, tl, ok, st);
    n_vec++;
    if (!ok || rd !== d) begin
      n_err++; $display("FAIL rd_data: got %h want %h", rd, d);
    end
    n_vec++;
    if (ri !== 4'd5 || lp !== 4'b1000) begin
      n_err++; $display("FAIL rd_id_last: rid=%h rlast=%b want rid=5 rlast=1000", ri, lp);
    end
    n_vec++;
    if (tf - ta != 2 || tl - ta != 5) begin
      n_err++; $display("FAIL rd_latency: first T+%0d last T+%0d want T+2 T+5", tf - ta, tl - ta);
    end
    n_vec++;
    if (bus.arready !== 1'b1 || cyc != tl + 1) begin
      n_err++; $display("FAIL arready_after_rlast: got %b want 1", bus.arready);
    end
  endtask

  task automatic test_byte_mask();
    logic bc; logic [3:0] bi, ri, lp; int ta, tb, tf, tl; bit ok, st;
    logic [127:0] rd;
    do_write(32'h200, 4'd1, 6'd0, 128'd0, 16'hFFFF, 4'b1000, 0, bc, bi, ta, tb, ok, st);
    do_write(32'h200, 4'd1, 6'd0, {4{32'hAABBCCDD}}, 16'h0555, 4'b1000, 0, bc, bi, ta, tb,
             ok, st);
    do_read(32'h200, 4'd1, 0, rd, lp, ri, ta, tf, tl, ok, st);
    n_vec++;
    if (!ok || rd !== {32'h00000000, 32'h00BB00DD, 32'h00BB00DD, 32'h00BB00DD}) begin
      n_err++; $display("FAIL byte_mask: got %h want 0000000000bb00dd00bb00dd00bb00dd", rd);
    end
    model_write(32'h200, 128'd0, 16'hFFFF);
    model_write(32'h200, {4{32'hAABBCCDD}}, 16'h0555);
  endtask

  task automatic test_errors();
    logic bc; logic [3:0] bi, ri, lp; int ta, tb, tf, tl; bit ok, st;
    logic [127:0] k = {32'hC0DE0003, 32'hC0DE0002, 32'hC0DE0001, 32'hC0DE0000};
    logic [127:0] rd;
    do_write(32'h300, 4'd2, 6'd0, k, 16'hFFFF, 4'b1000, 0, bc, bi, ta, tb, ok, st);
    model_write(32'h300, k, 16'hFFFF);
    do_write(32'h300, 4'd7, 6'h01, ~k, 16'hFFFF, 4'b1000, 0, bc, bi, ta, tb, ok, st);
    n_vec++;
    if (!ok || bc !== 1'b0 || bi !== 4'd7 || tb - ta != 5) begin
      n_err++; $display("FAIL atop_resp: bcomp=%b bid=%h lat=%0d want 0 7 5", bc, bi, tb - ta);
    end
    do_read(32'h300, 4'd0, 0, rd, lp, ri, ta, tf, tl, ok, st);
    n_vec++;
    if (!ok || rd !== k) begin
      n_err++; $display("FAIL atop_mem: got %h want %h", rd, k);
    end
    do_write(32'h500, 4'd4, 6'd0, k, 16'hFFFF, 4'b0100, 0, bc, bi, ta, tb, ok, st);
    n_vec++;
    if (!ok || bc !== 1'b0 || tb - ta != 5) begin
      n_err++; $display("FAIL wlast_early: bcomp=%b lat=%0d want 0 5", bc, tb - ta);
    end
    do_write(32'h600, 4'd4, 6'd0, k, 16'hFFFF, 4'b0000, 0, bc, bi, ta, tb, ok, st);
    n_vec++;
    if (!ok || bc !== 1'b0 || tb - ta != 5) begin
      n_err++; $display("FAIL wlast_missing: bcomp=%b lat=%0d want 0 5", bc, tb - ta);
    end
  endtask

  task automatic test_random_stalls();
    logic bc; logic [3:0] bi, ri, lp; int ta, tb, tf, tl; bit ok, st;
    logic [127:0] d, rd;
    logic [15:0] s;
    logic [31:0] a;
    bit known [int];
    logic [31:0] lines [$];
    for (int i = 0; i < 100; i++) begin
      a = 32'($urandom_range(32'h100, 32'h1FF)) << 4;
      d = {$urandom, $urandom, $urandom, $urandom};
      s = known.exists(int'(a)) ? 16'($urandom) : 16'hFFFF;
      do_write(a, 4'(i), 6'd0, d, s, 4'b1000, 1, bc, bi, ta, tb, ok, st);
      model_write(a, d, s);
      known[int'(a)] = 1;
      lines.push_back(a);
      n_vec++;
      if (!ok || !st || bc !== 1'b1 || bi !== 4'(i)) begin
        n_err++; $display("FAIL rnd_wr %0d: ok=%0d stable=%0d bcomp=%b bid=%h", i, ok, st, bc, bi);
      end
      if (i % 3 == 0) a = lines[$urandom_range(lines.size() - 1)];
      do_read(a, 4'(i + 1), 1, rd, lp, ri, ta, tf, tl, ok, st);
      n_vec++;
      if (!ok || !st || rd !== model_line(a) || lp !== 4'b1000 || ri !== 4'(i + 1)) begin
        n_err++;
        $display("FAIL rnd_rd %0d @%h: ok=%0d stable=%0d got %h want %h rlast=%b", i, a, ok, st,
                 rd, model_line(a), lp);
      end
    end
  endtask

  task automatic test_concurrent_alias();
    logic bc, bc2; logic [3:0] bi, bi2, ri, lp; int ta, tb, tf, tl, ta2, tb2; bit ok, ok2, st, st2;
    logic [127:0] d = {32'hFEED0004, 32'hFEED0003, 32'hFEED0002, 32'hFEED0001};
    logic [127:0] rd;
    fork
      do_write(32'h2000, 4'd9, 6'd0, d, 16'hFFFF, 4'b1000, 0, bc, bi, ta, tb, ok, st);
      do_read(32'h100, 4'd6, 0, rd, lp, ri, ta2, tf, tl, ok2, st2);
    join
    model_write(32'h2000, d, 16'hFFFF);
    n_vec++;
    if (!ok || !ok2 || bc !== 1'b1 || rd !== model_line(32'h100)) begin
      n_err++; $display("FAIL concurrent: bcomp=%b rd=%h want 1 %h", bc, rd, model_line(32'h100));
    end
    do_read(32'h2000, 4'd6, 0, rd, lp, ri, ta, tf, tl, ok, st);
    n_vec++;
    if (!ok || rd !== d) begin
      n_err++; $display("FAIL concurrent_wr: got %h want %h", rd, d);
    end
    do_write(32'h0004_0100, 4'd2, 6'd0, ~d, 16'hFFFF, 4'b1000, 0, bc2, bi2, ta2, tb2, ok, st);
    do_read(32'h100, 4'd2, 0, rd, lp, ri, ta, tf, tl, ok2, st);
    n_vec++;
    if (!ok || !ok2 || rd !== ~d) begin
      n_err++; $display("FAIL alias: got %h want %h", rd, ~d);
    end
    model_write(32'h100, ~d, 16'hFFFF);
  endtask

  task automatic test_reset_mid_read();
    int guard = 0;
    @(negedge clk);
    bus.arvalid = 1'b1; bus.araddr = 32'h100; bus.arid = 4'd8; bus.rready = 1'b0;
    @(negedge clk);
    bus.arvalid = 1'b0;
    while (!bus.rvalid && guard < 20) begin @(negedge clk); guard++; end
    n_vec++;
    if (bus.rvalid !== 1'b1) begin
      n_err++; $display("FAIL midrd_start: rvalid=%b want 1", bus.rvalid);
    end
    rst_n = 1'b0;
    #1;
    n_vec++;
    if ({bus.rvalid, bus.rlast, bus.arready} !== 3'b000 || bus.rdata !== 32'd0) begin
      n_err++; $display("FAIL midrd_reset: rvalid=%b rlast=%b arready=%b rdata=%h want 0",
                        bus.rvalid, bus.rlast, bus.arready, bus.rdata);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_vec++;
    if ({bus.arready, bus.awready, bus.rvalid} !== 3'b110) begin
      n_err++; $display("FAIL midrd_release: arready=%b awready=%b rvalid=%b want 1 1 0",
                        bus.arready, bus.awready, bus.rvalid);
    end
  endtask

  initial begin
    bus.awvalid = 1'b0; bus.awid = '0; bus.awaddr = '0; bus.awatop = '0;
    bus.wvalid = 1'b0; bus.wdata = '0; bus.wstrb = '0; bus.wlast = 1'b0;
    bus.bready = 1'b0; bus.arvalid = 1'b0; bus.arid = '0; bus.araddr = '0;
    bus.rready = 1'b0;
    test_reset();
    test_write_read();
    test_byte_mask();
    test_errors();
    test_random_stalls();
    test_concurrent_alias();
    test_reset_mid_read();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
